// File: rtl/domain_control_pkg.sv
// domain_control_pkg: shared state encoding and default parameters for the domain bring-up controller
package domain_control_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_INIT      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int DEF_RST_SYNC_STAGES    = 2;
  localparam int DEF_LOCK_SYNC_STAGES   = 2;
  localparam int DEF_LOCK_STABLE_CYCLES = 8;

endpackage

// File: rtl/domain_control_unit_bit_sync_chain.sv
// bit_sync_chain: single-bit multi-flop synchronizer with asynchronous active-low clear
module bit_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // shift the input through the chain; clear asynchronously so the output starts low
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/domain_control_unit.sv
// domain_control_unit: qualifies async reset and clock lock, drives sync_rst/clk_en/init for one domain.
// Define DOMAIN_CONTROL_LOCK_LOSS_RESET_EN to drop back to WAIT_LOCK on lock loss after release;
// otherwise lock is qualified once per async reset and ignored afterwards.
module domain_control_unit
  import domain_control_pkg::*;
#(
  parameter int RST_SYNC_STAGES    = DEF_RST_SYNC_STAGES,
  parameter int LOCK_SYNC_STAGES   = DEF_LOCK_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES
) (
  input  logic clk,
  input  logic async_rst,
  input  logic clk_lock,
  output logic clk_en,
  output logic sync_rst,
  output logic init
);

  localparam int CW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(LOCK_STABLE_CYCLES);

  logic          w_rst_ok;
  logic          w_lock_s;
  logic          w_lock_lost;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_clk_en;
  logic          r_sync_rst;
  logic          r_init;

  bit_sync_chain #(.STAGES(RST_SYNC_STAGES)) u_rst_sync (
    .i_clk   (clk),
    .i_rst_n (async_rst),
    .i_d     (1'b1),
    .o_q     (w_rst_ok)
  );

  bit_sync_chain #(.STAGES(LOCK_SYNC_STAGES)) u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (async_rst),
    .i_d     (clk_lock),
    .o_q     (w_lock_s)
  );

`ifdef DOMAIN_CONTROL_LOCK_LOSS_RESET_EN
  assign w_lock_lost = ~w_lock_s;
`else
  assign w_lock_lost = 1'b0;
`endif

  // bring-up FSM with stable-lock counter; outputs registered alongside each transition.
  // The lock sample taken on the RESET->WAIT_LOCK edge already counts toward stability,
  // and release happens on the edge after the count has reached LOCK_STABLE_CYCLES.
  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      r_state    <= ST_RESET;
      r_cnt      <= '0;
      r_clk_en   <= 1'b0;
      r_sync_rst <= 1'b1;
      r_init     <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (w_rst_ok) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= CW'(w_lock_s);
          end
        end
        ST_WAIT_LOCK: begin
          if (!w_lock_s) begin
            r_cnt <= '0;
          end else if (r_cnt == STABLE_MAX) begin
            r_state    <= ST_INIT;
            r_cnt      <= '0;
            r_sync_rst <= 1'b0;
            r_init     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_INIT: begin
          r_init <= 1'b0;
          if (w_lock_lost) begin
            r_state    <= ST_WAIT_LOCK;
            r_sync_rst <= 1'b1;
          end else begin
            r_state  <= ST_RUN;
            r_clk_en <= 1'b1;
          end
        end
        default: begin
          if (w_lock_lost) begin
            r_state    <= ST_WAIT_LOCK;
            r_sync_rst <= 1'b1;
            r_clk_en   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign clk_en   = r_clk_en;
  assign sync_rst = r_sync_rst;
  assign init     = r_init;

endmodule

// File: tb/tb_domain_control_unit.sv
// tb_domain_control_unit: randomized and directed checks of domain_control_unit against a streak-based reference model
module tb_domain_control_unit;

  localparam int RSS = 2;
  localparam int LSS = 2;
  localparam int LSC = 8;

  logic clk = 1'b0;
  logic async_rst = 1'b0;
  logic clk_lock = 1'b0;
  logic clk_en;
  logic sync_rst;
  logic init;

  int n_chk = 0;
  int n_pass = 0;

  // reference model: released once LSC+1 consecutive edges saw both reset-ok and synchronized lock
  int   m_edges;
  int   m_streak;
  bit   m_up;
  bit   m_first;
  logic m_lq[$];

  domain_control_unit #(
    .RST_SYNC_STAGES    (RSS),
    .LOCK_SYNC_STAGES   (LSS),
    .LOCK_STABLE_CYCLES (LSC)
  ) dut (
    .clk      (clk),
    .async_rst(async_rst),
    .clk_lock (clk_lock),
    .clk_en   (clk_en),
    .sync_rst (sync_rst),
    .init     (init)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_edges  = 0;
    m_streak = 0;
    m_up     = 1'b0;
    m_first  = 1'b0;
    m_lq     = {};
    for (int i = 0; i < LSS; i++) m_lq.push_back(1'b0);
  endtask

  task automatic model_edge();
    logic lk;
    bit   rok;
    if (!async_rst) return;
    lk  = m_lq.pop_front();
    m_lq.push_back(clk_lock);
    rok = (m_edges >= RSS);
    m_edges++;
    if (m_up) begin
`ifdef DOMAIN_CONTROL_LOCK_LOSS_RESET_EN
      if (!lk) begin
        m_up     = 1'b0;
        m_streak = 0;
      end
`endif
      m_first = 1'b0;
    end else begin
      m_streak = (rok && lk) ? m_streak + 1 : 0;
      if (m_streak == LSC + 1) begin
        m_up     = 1'b1;
        m_first  = 1'b1;
        m_streak = 0;
      end
    end
  endtask

  task automatic check_outs();
    chk("sync_rst", int'(sync_rst), int'(!m_up));
    chk("clk_en", int'(clk_en), int'(m_up && !m_first));
    chk("init", int'(init), int'(m_up && m_first));
  endtask

  task automatic step(input logic r, input logic l);
    @(negedge clk);
    async_rst = r;
    clk_lock  = l;
    if (!r) model_reset();
    #1 check_outs();
    @(posedge clk);
    model_edge();
    #1 check_outs();
  endtask

  task automatic run(input int n, input logic r, input logic l);
    for (int i = 0; i < n; i++) step(r, l);
  endtask

  task automatic measure(input string tag, input int want);
    int lat = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1);
      if (init && lat < 0) lat = i + 1;
    end
    chk(tag, lat, want);
  endtask

  initial begin
    logic l;
    logic r;
    model_reset();
    run(5, 1'b0, 1'b0);
    run(5, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, i[0]);
    run(2, 1'b0, 1'b1);
    measure("release_latency", RSS + LSC + 1);
    run(4, 1'b1, 1'b0);
    run(15, 1'b1, 1'b1);
    step(1'b0, 1'b1);
    run(20, 1'b1, 1'b1);
    step(1'b0, 1'b0);
    run(20, 1'b1, 1'b0);
    measure("lock_latency", LSS + LSC + 1);
    step(1'b0, 1'b0);
    run(5, 1'b1, 1'b0);
    run(5, 1'b1, 1'b1);
    run(1, 1'b1, 1'b0);
    run(15, 1'b1, 1'b1);
    l = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 14) == 0) l = ~l;
      r = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      step(r, l);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
